ps2_scan_receiver: RTL and testbench

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

---
 rtl/ps2_scan_receiver_if.sv | 36 +++
 rtl/ps2_scan_receiver.sv | 174 +++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_receiver_if
// Description : Groups the PS/2 pin pair and the received-byte outputs of
//               the scan-code receiver into one bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface ps2_scan_receiver_if;
    logic        kclk;
    logic        data;
    logic [15:0] lastSent;
    logic        byteValid;
    logic        frameErr;
    logic        led;

    // Keyboard/stimulus side: drives the PS/2 pins, observes the results
    modport master (
        output kclk,
        output data,
        input  lastSent,
        input  byteValid,
        input  frameErr,
        input  led
    );

    // Receiver side: samples the PS/2 pins, drives the results
    modport slave (
        input  kclk,
        input  data,
        output lastSent,
        output byteValid,
        output frameErr,
        output led
    );
endinterface
`default_nettype wire

// File: rtl/ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_receiver
// Description : PS/2 keyboard frame receiver. Synchronizes kclk/data,
//               samples one bit per kclk falling edge, checks start, odd
//               parity and stop, and keeps the last two accepted bytes.
// Revision    : 1.0  initial release
// ============================================================================
module ps2_scan_receiver #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    ps2_scan_receiver_if.slave bus
);

    localparam int c_TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_WIDTH-1:0] c_TO_LIMIT = c_TO_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [7:0] c_BREAK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] kclk_sync_q, kclk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   kclk_prev_q, kclk_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_ok_q, parity_ok_d;
    logic [c_TO_WIDTH-1:0]  timeout_q, timeout_d;
    logic                   accept_q, accept_d;
    logic [15:0]            last_sent_q, last_sent_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   led_q, led_d;

    logic w_fall_strobe;
    logic w_data_bit;
    logic w_timeout_hit;
    logic w_err_set;

    // Falling edge of the synchronized clock and the bit it qualifies
    assign w_fall_strobe = kclk_prev_q & ~kclk_sync_q[SYNC_STAGES-1];
    assign w_data_bit    = data_sync_q[SYNC_STAGES-1];
    assign w_timeout_hit = (state_q != IDLE) && (timeout_q == c_TO_LIMIT);

    // Next-state logic: synchronizers, frame FSM, timeout and output update
    always_comb begin
        kclk_sync_d    = kclk_sync_q;
        data_sync_d    = data_sync_q;
        kclk_sync_d[0] = bus.kclk;
        data_sync_d[0] = bus.data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            kclk_sync_d[i] = kclk_sync_q[i-1];
            data_sync_d[i] = data_sync_q[i-1];
        end
        kclk_prev_d  = kclk_sync_q[SYNC_STAGES-1];
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_ok_d  = parity_ok_q;
        timeout_d    = timeout_q;
        accept_d     = 1'b0;
        last_sent_d  = last_sent_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        led_d        = led_q;
        w_err_set    = 1'b0;

        // Timeout counter runs only inside a frame and restarts on each bit
        if (state_q == IDLE || w_fall_strobe) begin
            timeout_d = '0;
        end else if (timeout_q != c_TO_LIMIT) begin
            timeout_d = timeout_q + c_TO_WIDTH'(1);
        end

        // Expiry wins over a coincident strobe; that strobe is dropped
        if (w_timeout_hit) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            timeout_d = '0;
            w_err_set = 1'b1;
        end else if (w_fall_strobe) begin
            case (state_q)
                IDLE: begin
                    if (!w_data_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                DATA: begin
                    shift_d[bit_cnt_q] = w_data_bit;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = PARITY;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    parity_ok_d = ^{shift_q, w_data_bit};
                    state_d     = STOP;
                end
                STOP: begin
                    if (w_data_bit && parity_ok_q) begin
                        accept_d = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                    state_d = IDLE;
                end
            endcase
        end

        // Accepted byte is published one cycle after the stop bit
        if (accept_q) begin
            last_sent_d  = {last_sent_q[7:0], shift_q};
            byte_valid_d = 1'b1;
            frame_err_d  = 1'b0;
            led_d        = (shift_q == c_BREAK_CODE);
        end
        if (w_err_set) begin
            frame_err_d = 1'b1;
        end
    end

    // State registers; synchronizers reset to the idle-high bus level
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            kclk_sync_q  <= '1;
            data_sync_q  <= '1;
            kclk_prev_q  <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_ok_q  <= 1'b0;
            timeout_q    <= '0;
            accept_q     <= 1'b0;
            last_sent_q  <= 16'h0000;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            kclk_sync_q  <= kclk_sync_d;
            data_sync_q  <= data_sync_d;
            kclk_prev_q  <= kclk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_ok_q  <= parity_ok_d;
            timeout_q    <= timeout_d;
            accept_q     <= accept_d;
            last_sent_q  <= last_sent_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            led_q        <= led_d;
        end
    end

    assign bus.lastSent  = last_sent_q;
    assign bus.byteValid = byte_valid_q;
    assign bus.frameErr  = frame_err_q;
    assign bus.led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scan_receiver
// Description : Directed self-checking bench for ps2_scan_receiver.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_scan_receiver;

    localparam int c_TIMEOUT = 200;
    localparam int c_SYNC    = 2;
    localparam int c_HALF    = 8;

    logic Clk;
    logic Reset;
    int   n_vec      = 0;
    int   n_miss     = 0;
    int   pulse_cnt  = 0;
    int   pulse_snap = 0;
    int   last_lat   = 0;

    ps2_scan_receiver_if bus ();

    ps2_scan_receiver #(
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .SYNC_STAGES    (c_SYNC)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count every cycle byteValid is high
    always @(posedge Clk) begin
        if (bus.byteValid) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One PS/2 bit: data set while kclk high, then a kclk low phase
    task automatic ps2_bit(input logic b);
        bus.data = b;
        repeat (c_HALF) @(negedge Clk);
        bus.kclk = 1'b0;
        for (int k = 1; k <= c_HALF; k++) begin
            @(posedge Clk);
            #1;
            if (bus.byteValid && last_lat == 0) last_lat = k;
        end
        @(negedge Clk);
        bus.kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        last_lat = 0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
        ps2_bit(stop);
        repeat (3) @(negedge Clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n_data);
        ps2_bit(1'b0);
        for (int i = 0; i < n_data; i++) ps2_bit(b[i]);
    endtask

    initial begin
        Reset    = 1'b1;
        bus.kclk = 1'b1;
        bus.data = 1'b1;
        repeat (4) @(negedge Clk);
        chk("rst_lastSent", {16'h0, bus.lastSent}, 32'h0);
        chk("rst_byteValid", {31'h0, bus.byteValid}, 32'h0);
        chk("rst_frameErr", {31'h0, bus.frameErr}, 32'h0);
        chk("rst_led", {31'h0, bus.led}, 32'h0);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        // Single good frame, including pin-to-byteValid latency
        pulse_snap = pulse_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("f1_lastSent", {16'h0, bus.lastSent}, 32'h001C);
        chk("f1_pulses", pulse_cnt - pulse_snap, 32'd1);
        chk("f1_frameErr", {31'h0, bus.frameErr}, 32'h0);
        chk("f1_led", {31'h0, bus.led}, 32'h0);
        chk("f1_latency", last_lat, c_SYNC + 2);

        // Break prefix then make code, back to back
        pulse_snap = pulse_cnt;
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("f0_lastSent", {16'h0, bus.lastSent}, 32'h1CF0);
        chk("f0_led", {31'h0, bus.led}, 32'h1);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("f2_lastSent", {16'h0, bus.lastSent}, 32'hF01C);
        chk("f2_led", {31'h0, bus.led}, 32'h0);
        chk("f2_pulses", pulse_cnt - pulse_snap, 32'd2);

        // Parity error, then recovery
        pulse_snap = pulse_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("par_pulses", pulse_cnt - pulse_snap, 32'd0);
        chk("par_lastSent", {16'h0, bus.lastSent}, 32'hF01C);
        chk("par_frameErr", {31'h0, bus.frameErr}, 32'h1);
        send_frame(8'h32, 1'b0, 1'b1);
        chk("rec_frameErr", {31'h0, bus.frameErr}, 32'h0);
        chk("rec_lastSent", {16'h0, bus.lastSent}, 32'h1C32);

        // Timeout mid-frame, then a clean frame
        pulse_snap = pulse_cnt;
        send_partial(8'h55, 4);
        repeat (c_TIMEOUT + 5) @(negedge Clk);
        chk("to_frameErr", {31'h0, bus.frameErr}, 32'h1);
        chk("to_pulses", pulse_cnt - pulse_snap, 32'd0);
        send_frame(8'h21, 1'b0, 1'b1);
        chk("to_lastSent", {16'h0, bus.lastSent}, 32'h3221);
        chk("to_rec_frameErr", {31'h0, bus.frameErr}, 32'h0);

        // Reset in the middle of a frame
        pulse_snap = pulse_cnt;
        send_partial(8'hA7, 4);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("mr_lastSent", {16'h0, bus.lastSent}, 32'h0);
        chk("mr_frameErr", {31'h0, bus.frameErr}, 32'h0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        send_frame(8'h45, 1'b0, 1'b1);
        chk("mr_after", {16'h0, bus.lastSent}, 32'h0045);
        chk("mr_pulses", pulse_cnt - pulse_snap, 32'd1);

        // Bad stop bit
        pulse_snap = pulse_cnt;
        send_frame(8'h45, 1'b0, 1'b0);
        chk("stop_frameErr", {31'h0, bus.frameErr}, 32'h1);
        chk("stop_pulses", pulse_cnt - pulse_snap, 32'd0);
        chk("stop_lastSent", {16'h0, bus.lastSent}, 32'h0045);
        send_frame(8'h12, 1'b0, 1'b1);
        chk("clr_frameErr", {31'h0, bus.frameErr}, 32'h0);

        // Lone falling edge with data high while idle
        pulse_snap = pulse_cnt;
        ps2_bit(1'b1);
        repeat (4) @(negedge Clk);
        chk("lone_frameErr", {31'h0, bus.frameErr}, 32'h1);
        chk("lone_pulses", pulse_cnt - pulse_snap, 32'd0);
        chk("lone_lastSent", {16'h0, bus.lastSent}, 32'h4512);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
